// File: rtl/mux_2x1_pkg.sv
// Shared types for the registered 2:1 mux: select encoding and the legal width ceiling.
package mux_2x1_pkg;

  typedef enum logic {
    SEL_IN1 = 1'b0,
    SEL_IN2 = 1'b1
  } sel_e;

  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/mux_2x1.sv
// Registered 2:1 mux with output enable: one cycle from sampled inputs to out/out_valid.
module mux_2x1
  import mux_2x1_pkg::*;
#(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] in1,
  input  logic [width-1:0] in2,
  input  logic             sel,
  input  logic             enable,
  output logic [width-1:0] out,
  output logic             out_valid
);

  if (width < 1 || width > WIDTH_MAX) begin : g_bad_width
    $error("mux_2x1: width must be within 1..%0d", WIDTH_MAX);
  end

  sel_e             sel_s;
  logic [width-1:0] out_d, out_q;
  logic             valid_d, valid_q;

  assign sel_s = sel_e'(sel);

  always_comb begin
    out_d   = '0;
    valid_d = enable;
    if (enable) begin
      out_d = (sel_s == SEL_IN2) ? in2 : in1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  // Outputs come straight from flops, so nothing downstream sees input-to-output paths.
  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_2x1.sv
// Scoreboard bench for mux_2x1 at widths 16 (directed + random), 1 and 64 (random sweep).
module tb_mux_2x1;

  typedef struct packed {
    logic [15:0] d;
    logic        v;
  } exp16_t;

  typedef struct packed {
    logic [0:0] d;
    logic       v;
  } exp1_t;

  typedef struct packed {
    logic [63:0] d;
    logic        v;
  } exp64_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst16, sel16, en16, v16;
  logic [15:0] a16, b16, out16;
  logic        rst1, sel1, en1, v1;
  logic [0:0]  a1, b1, out1;
  logic        rst64, sel64, en64, v64;
  logic [63:0] a64, b64, out64;

  int tests    = 0;
  int failures = 0;

  exp16_t q16[$];
  exp1_t  q1[$];
  exp64_t q64[$];

  mux_2x1 #(.width(16)) dut16 (
    .clk(clk), .rst(rst16), .in1(a16), .in2(b16), .sel(sel16),
    .enable(en16), .out(out16), .out_valid(v16)
  );

  mux_2x1 #(.width(1)) dut1 (
    .clk(clk), .rst(rst1), .in1(a1), .in2(b1), .sel(sel1),
    .enable(en1), .out(out1), .out_valid(v1)
  );

  mux_2x1 #(.width(64)) dut64 (
    .clk(clk), .rst(rst64), .in1(a64), .in2(b64), .sel(sel64),
    .enable(en64), .out(out64), .out_valid(v64)
  );

  function automatic exp16_t model16(logic r, logic e, logic s, logic [15:0] x, logic [15:0] y);
    exp16_t t;
    t.v = !r && e;
    t.d = t.v ? (s ? y : x) : 16'h0000;
    return t;
  endfunction

  function automatic exp1_t model1(logic r, logic e, logic s, logic [0:0] x, logic [0:0] y);
    exp1_t t;
    t.v = !r && e;
    t.d = t.v ? (s ? y : x) : 1'b0;
    return t;
  endfunction

  function automatic exp64_t model64(logic r, logic e, logic s, logic [63:0] x, logic [63:0] y);
    exp64_t t;
    t.v = !r && e;
    t.d = t.v ? (s ? y : x) : 64'h0;
    return t;
  endfunction

  // Unknown select while enabled is a usage error and is reported as a failure.
  always @(posedge clk) begin
    if (!rst16 && en16 === 1'b1 && $isunknown(sel16)) begin
      failures++;
      $display("FAIL sel_x: sel=%b with enable=1, required a known select", sel16);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time=%0t, required completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    exp16_t e;
    rst16 = 1'b1; a16 = 16'hFFF0; b16 = 16'h0AAA; sel16 = 1'b0; en16 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q16.push_back(model16(rst16, en16, sel16, a16, b16));
      @(posedge clk); #1;
      e = q16.pop_front();
      tests++;
      if ({out16, v16} !== {e.d, e.v}) begin
        failures++;
        $display("FAIL reset[%0d]: out=%h valid=%b, required out=%h valid=%b", i, out16, v16, e.d, e.v);
      end
    end
  endtask

  task automatic test_select_in1();
    exp16_t e;
    rst16 = 1'b0; a16 = 16'hFFF0; b16 = 16'h0AAA; sel16 = 1'b0; en16 = 1'b1;
    q16.push_back(model16(rst16, en16, sel16, a16, b16));
    @(posedge clk); #1;
    e = q16.pop_front();
    tests++;
    if ({out16, v16} !== {e.d, e.v} || out16 !== 16'hFFF0) begin
      failures++;
      $display("FAIL select_in1: out=%h valid=%b, required out=%h valid=%b", out16, v16, e.d, e.v);
    end
  endtask

  task automatic test_select_in2();
    exp16_t e;
    sel16 = 1'b1;
    #1;
    tests++;
    if (out16 !== 16'hFFF0 || v16 !== 1'b1) begin
      failures++;
      $display("FAIL select_in2_hold: out=%h valid=%b, required out=fff0 valid=1", out16, v16);
    end
    q16.push_back(model16(rst16, en16, sel16, a16, b16));
    @(posedge clk); #1;
    e = q16.pop_front();
    tests++;
    if ({out16, v16} !== {e.d, e.v} || out16 !== 16'h0AAA) begin
      failures++;
      $display("FAIL select_in2: out=%h valid=%b, required out=%h valid=%b", out16, v16, e.d, e.v);
    end
  endtask

  task automatic test_disable();
    exp16_t e;
    en16 = 1'b0;
    #1;
    tests++;
    if (out16 !== 16'h0AAA || v16 !== 1'b1) begin
      failures++;
      $display("FAIL disable_hold: out=%h valid=%b, required out=0aaa valid=1", out16, v16);
    end
    for (int i = 0; i < 2; i++) begin
      q16.push_back(model16(rst16, en16, sel16, a16, b16));
      @(posedge clk); #1;
      e = q16.pop_front();
      tests++;
      if ({out16, v16} !== {e.d, e.v}) begin
        failures++;
        $display("FAIL disable[%0d]: out=%h valid=%b, required out=%h valid=%b", i, out16, v16, e.d, e.v);
      end
      en16 = 1'b1;
    end
  endtask

  task automatic test_mid_reset();
    exp16_t e;
    rst16 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q16.push_back(model16(rst16, en16, sel16, a16, b16));
      @(posedge clk); #1;
      e = q16.pop_front();
      tests++;
      if ({out16, v16} !== {e.d, e.v}) begin
        failures++;
        $display("FAIL mid_reset[%0d]: out=%h valid=%b, required out=%h valid=%b", i, out16, v16, e.d, e.v);
      end
      rst16 = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    exp16_t e;
    for (int i = 0; i < 300; i++) begin
      rst16 = ($urandom_range(0, 19) == 0);
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      sel16 = 1'($urandom);
      en16  = ($urandom_range(0, 3) != 0);
      q16.push_back(model16(rst16, en16, sel16, a16, b16));
      @(posedge clk); #1;
      e = q16.pop_front();
      tests++;
      if ({out16, v16} !== {e.d, e.v}) begin
        failures++;
        $display("FAIL back_to_back[%0d]: out=%h valid=%b, required out=%h valid=%b", i, out16, v16, e.d, e.v);
      end
    end
  endtask

  task automatic test_width_sweep();
    exp1_t  e1;
    exp64_t e64;
    for (int i = 0; i < 1000; i++) begin
      rst1  = (i == 0);
      a1    = 1'($urandom);
      b1    = 1'($urandom);
      sel1  = 1'($urandom);
      en1   = 1'($urandom);
      rst64 = (i == 0);
      a64   = {$urandom, $urandom};
      b64   = {$urandom, $urandom};
      sel64 = 1'($urandom);
      en64  = 1'($urandom);
      q1.push_back(model1(rst1, en1, sel1, a1, b1));
      q64.push_back(model64(rst64, en64, sel64, a64, b64));
      @(posedge clk); #1;
      e1  = q1.pop_front();
      e64 = q64.pop_front();
      tests++;
      if ({out1, v1} !== {e1.d, e1.v}) begin
        failures++;
        $display("FAIL sweep_w1[%0d]: out=%b valid=%b, required out=%b valid=%b", i, out1, v1, e1.d, e1.v);
      end
      tests++;
      if ({out64, v64} !== {e64.d, e64.v}) begin
        failures++;
        $display("FAIL sweep_w64[%0d]: out=%h valid=%b, required out=%h valid=%b", i, out64, v64, e64.d, e64.v);
      end
    end
  endtask

  initial begin
    rst16 = 1'b1; a16 = '0; b16 = '0; sel16 = 1'b0; en16 = 1'b0;
    rst1  = 1'b1; a1  = '0; b1  = '0; sel1  = 1'b0; en1  = 1'b0;
    rst64 = 1'b1; a64 = '0; b64 = '0; sel64 = 1'b0; en64 = 1'b0;
    test_reset();
    test_select_in1();
    test_select_in2();
    test_disable();
    test_mid_reset();
    test_back_to_back();
    test_width_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
